// File: rtl/tron_pkg.sv
// Shared definitions for the light-cycle match controller: LED state
// encodings and default match sizing.
package tron_pkg;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_PLAY       = 2'b01;
  localparam logic [1:0] ST_ROUND_OVER = 2'b10;
  localparam logic [1:0] ST_DONE       = 2'b11;

  localparam int unsigned DEF_SCORE_W   = 4;
  localparam int unsigned DEF_WIN_SCORE = 10;

endpackage

// File: rtl/tron_game_ctrl_if.sv
// Controller <-> player/trail datapath link: collision reports in, move and
// round-reload strobes out.
interface tron_game_ctrl_if;
  logic p1_hit;
  logic p2_hit;
  logic move_en;
  logic round_clear;

  modport master (input p1_hit, input p2_hit, output move_en, output round_clear);
  modport slave  (output p1_hit, output p2_hit, input move_en, input round_clear);
endinterface

// File: rtl/tron_tick_gen.sv
// Move-period divider: counts 0..TICK_DIV-1 while enabled and flags the wrap
// cycle. A synchronous clear restarts the period and masks the wrap.
module tron_tick_gen #(
  parameter int unsigned TICK_DIV = 2097152
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tron_tick_gen: TICK_DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap = en && !clr && (cnt_q == CNT_MAX);

  // Next count: clear wins, then wrap-around or increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tron_game_ctrl.sv
// Round/match sequencer for the two-player light-cycle game: match FSM,
// move strobe generation, crash scoring and winner declaration.
// Optional build macro TRON_AUTO_SERVE_EN: rounds restart by themselves after
// SERVE_TICKS move periods instead of waiting for a start switch edge.
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 2097152,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  parameter int unsigned SERVE_TICKS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  tron_game_ctrl_if.master    dp,
  output logic [1:0]          state,
  output logic [SCORE_W-1:0]  p1_score,
  output logic [SCORE_W-1:0]  p2_score,
  output logic                p1_win,
  output logic                p2_win
);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam int unsigned        SERVE_W = $clog2(SERVE_TICKS + 1);

  if (WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win
    $error("tron_game_ctrl: WIN_SCORE must fit in SCORE_W bits");
  end
  if (SERVE_TICKS < 1) begin : g_bad_serve
    $error("tron_game_ctrl: SERVE_TICKS must be >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic               p1_win_q, p1_win_d;
  logic               p2_win_q, p2_win_d;
  logic               move_en_q, move_en_d;
  logic               round_clear_q, round_clear_d;
  logic               armed_q, armed_d;
  logic               start_q, start_d;
  logic               tick_clr, tick_en, tick_wrap;
  logic               start_rise;
  logic               any_hit;
`ifdef TRON_AUTO_SERVE_EN
  logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
`endif

  tron_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .en      (tick_en),
    .wrap    (tick_wrap)
  );

  assign start_d    = start;
  assign start_rise = start && !start_q;
  assign any_hit    = dp.p1_hit || dp.p2_hit;

  // Match FSM, scoring and strobe generation.
  always_comb begin
    state_d       = state_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    p1_win_d      = p1_win_q;
    p2_win_d      = p2_win_q;
    armed_d       = armed_q;
    move_en_d     = 1'b0;
    round_clear_d = 1'b0;
    tick_clr      = 1'b0;
    tick_en       = 1'b0;
`ifdef TRON_AUTO_SERVE_EN
    serve_cnt_d   = serve_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d       = ST_PLAY;
          p1_score_d    = '0;
          p2_score_d    = '0;
          armed_d       = 1'b0;
          round_clear_d = 1'b1;
          tick_clr      = 1'b1;
        end
      end
      ST_PLAY: begin
        tick_en = 1'b1;
        if (armed_q && any_hit) begin
          // A crash takes precedence over a coincident move period.
          state_d  = ST_ROUND_OVER;
          tick_clr = 1'b1;
`ifdef TRON_AUTO_SERVE_EN
          serve_cnt_d = '0;
`endif
          if (dp.p1_hit && !dp.p2_hit && (p2_score_q != WIN))
            p2_score_d = p2_score_q + 1'b1;
          if (dp.p2_hit && !dp.p1_hit && (p1_score_q != WIN))
            p1_score_d = p1_score_q + 1'b1;
        end else if (tick_wrap) begin
          move_en_d = 1'b1;
          armed_d   = 1'b1;
        end
      end
      ST_ROUND_OVER: begin
        armed_d = 1'b0;
        if (p1_score_q == WIN) begin
          state_d  = ST_DONE;
          p1_win_d = 1'b1;
        end else if (p2_score_q == WIN) begin
          state_d  = ST_DONE;
          p2_win_d = 1'b1;
        end else begin
`ifdef TRON_AUTO_SERVE_EN
          // Serve pause is measured in move periods from the same divider.
          tick_en = 1'b1;
          if (tick_wrap) begin
            if (serve_cnt_q == SERVE_W'(SERVE_TICKS - 1)) begin
              state_d       = ST_PLAY;
              serve_cnt_d   = '0;
              round_clear_d = 1'b1;
              tick_clr      = 1'b1;
            end else begin
              serve_cnt_d = serve_cnt_q + 1'b1;
            end
          end
`else
          if (start_rise) begin
            state_d       = ST_PLAY;
            round_clear_d = 1'b1;
            tick_clr      = 1'b1;
          end
`endif
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d  = ST_IDLE;
          p1_win_d = 1'b0;
          p2_win_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, score and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      p1_win_q      <= 1'b0;
      p2_win_q      <= 1'b0;
      move_en_q     <= 1'b0;
      round_clear_q <= 1'b0;
      armed_q       <= 1'b0;
      start_q       <= 1'b1;
`ifdef TRON_AUTO_SERVE_EN
      serve_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      p1_win_q      <= p1_win_d;
      p2_win_q      <= p2_win_d;
      move_en_q     <= move_en_d;
      round_clear_q <= round_clear_d;
      armed_q       <= armed_d;
      start_q       <= start_d;
`ifdef TRON_AUTO_SERVE_EN
      serve_cnt_q   <= serve_cnt_d;
`endif
    end
  end

  assign state          = state_q;
  assign p1_score       = p1_score_q;
  assign p2_score       = p2_score_q;
  assign p1_win         = p1_win_q;
  assign p2_win         = p2_win_q;
  assign dp.move_en     = move_en_q;
  assign dp.round_clear = round_clear_q;
endmodule
